// File: rtl/ieee488_handshake_if.sv
// IEEE-488 three-wire handshake bus pins and open-collector drive enables.
// Ports: *_n raw active-low pins seen by the engine; *_drv 1 = pull line low.
interface ieee488_handshake_if;
   logic [7:0] dio_n;
   logic       dav_n;
   logic       nrfd_n;
   logic       ndac_n;
   logic       eoi_n;
   logic [7:0] dio_drv;
   logic       dav_drv;
   logic       nrfd_drv;
   logic       ndac_drv;
   logic       eoi_drv;

   modport master (
      input  dio_n, dav_n, nrfd_n, ndac_n, eoi_n,
      output dio_drv, dav_drv, nrfd_drv, ndac_drv, eoi_drv
   );

   modport slave (
      output dio_n, dav_n, nrfd_n, ndac_n, eoi_n,
      input  dio_drv, dav_drv, nrfd_drv, ndac_drv, eoi_drv
   );
endinterface

// File: rtl/ieee488_handshake.sv
// IEEE-488 DAV/NRFD/NDAC byte handshake engine, talker and listener modes.
// Ports: clk/_reset, talk/enable mode, tx stream in, 1-entry rx buffer out,
//   bus (pins in, drives out), busy and sticky err_timeout/err_dnp flags.
module ieee488_handshake #(
   parameter int SETTLE  = 4,
   parameter int TIMEOUT = 1024,
   parameter int CW      = 11
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       talk,
   input  logic       enable,
   input  logic [7:0] tx_data,
   input  logic       tx_eoi,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_eoi,
   output logic       rx_valid,
   input  logic       rx_ack,
   ieee488_handshake_if.master bus,
   output logic       busy,
   output logic       err_timeout,
   output logic       err_dnp
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SLOAD = SW'(SETTLE - 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

   typedef enum logic [3:0] {
      IDLE,
      T_LOAD,
      T_SETTLE,
      T_WAITRDY,
      T_WAITACC,
      T_WAITNDAC,
      T_ABORT,
      L_NOTREADY,
      L_READY,
      L_WAITDAV
   } state_t;

   state_t        state;
   logic [SW-1:0] scnt;
   logic [CW-1:0] tcnt;

   // Sync flops reset to 1: released (idle-high) bus lines.
   logic [11:0] s1;
   logic [11:0] s2;
   logic [7:0]  dio;
   logic        dav;
   logic        nrfd;
   logic        ndac;
   logic        eoi;

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         s1 <= '1;
         s2 <= '1;
      end else begin
         s1 <= {bus.eoi_n, bus.ndac_n, bus.nrfd_n,
                bus.dav_n, bus.dio_n};
         s2 <= s1;
      end
   end

   assign dio  = ~s2[7:0];
   assign dav  = ~s2[8];
   assign nrfd = ~s2[9];
   assign ndac = ~s2[10];
   assign eoi  = ~s2[11];

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state       <= IDLE;
         scnt        <= '0;
         tcnt        <= '0;
         tx_ready    <= 1'b0;
         rx_data     <= '0;
         rx_eoi      <= 1'b0;
         rx_valid    <= 1'b0;
         err_timeout <= 1'b0;
         err_dnp     <= 1'b0;
         {bus.dio_drv, bus.dav_drv, bus.nrfd_drv,
          bus.ndac_drv, bus.eoi_drv} <= '0;
      end else begin
         tx_ready <= 1'b0;
         tcnt     <= '0;
         if (rx_ack && rx_valid)
            rx_valid <= 1'b0;
         if (!enable) begin
            state       <= IDLE;
            err_timeout <= 1'b0;
            err_dnp     <= 1'b0;
            {bus.dio_drv, bus.dav_drv, bus.nrfd_drv,
             bus.ndac_drv, bus.eoi_drv} <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  {bus.dio_drv, bus.dav_drv, bus.nrfd_drv,
                   bus.ndac_drv, bus.eoi_drv} <= '0;
                  if (talk) begin
                     state <= T_LOAD;
                  end else begin
                     state        <= L_NOTREADY;
                     bus.nrfd_drv <= 1'b1;
                     bus.ndac_drv <= 1'b1;
                  end
               end
               T_LOAD: begin
                  if (tx_valid) begin
                     tx_ready    <= 1'b1;
                     bus.dio_drv <= tx_data;
                     bus.eoi_drv <= tx_eoi;
                     scnt        <= SLOAD;
                     state       <= T_SETTLE;
                  end
               end
               T_SETTLE: begin
                  if (scnt == '0)
                     state <= T_WAITRDY;
                  else
                     scnt <= scnt - 1'b1;
               end
               T_WAITRDY: begin
                  // Both lines released means no listener on the bus.
                  if (!nrfd && !ndac) begin
                     err_dnp <= 1'b1;
                     state   <= T_ABORT;
                     {bus.dio_drv, bus.dav_drv,
                      bus.eoi_drv} <= '0;
                  end else if (!nrfd && ndac) begin
                     bus.dav_drv <= 1'b1;
                     state       <= T_WAITACC;
                  end else if (tcnt == TMAX) begin
                     err_timeout <= 1'b1;
                     state       <= T_ABORT;
                     {bus.dio_drv, bus.dav_drv,
                      bus.eoi_drv} <= '0;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               T_WAITACC: begin
                  if (!ndac) begin
                     state <= T_WAITNDAC;
                     {bus.dio_drv, bus.dav_drv,
                      bus.eoi_drv} <= '0;
                  end else if (tcnt == TMAX) begin
                     err_timeout <= 1'b1;
                     state       <= T_ABORT;
                     {bus.dio_drv, bus.dav_drv,
                      bus.eoi_drv} <= '0;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               T_WAITNDAC: begin
                  if (ndac) begin
                     state <= T_LOAD;
                  end else if (tcnt == TMAX) begin
                     err_timeout <= 1'b1;
                     state       <= T_ABORT;
                  end else begin
                     tcnt <= tcnt + 1'b1;
                  end
               end
               T_ABORT: begin
                  state <= IDLE;
                  {bus.dio_drv, bus.dav_drv, bus.nrfd_drv,
                   bus.ndac_drv, bus.eoi_drv} <= '0;
               end
               L_NOTREADY: begin
                  bus.ndac_drv <= 1'b1;
                  bus.nrfd_drv <= 1'b1;
                  // A full buffer keeps NRFD asserted until popped.
                  if (!rx_valid && !dav) begin
                     bus.nrfd_drv <= 1'b0;
                     state        <= L_READY;
                  end
               end
               L_READY: begin
                  if (dav) begin
                     rx_data      <= dio;
                     rx_eoi       <= eoi;
                     rx_valid     <= 1'b1;
                     bus.nrfd_drv <= 1'b1;
                     bus.ndac_drv <= 1'b0;
                     state        <= L_WAITDAV;
                  end
               end
               L_WAITDAV: begin
                  if (!dav) begin
                     bus.ndac_drv <= 1'b1;
                     state        <= L_NOTREADY;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ieee488_handshake.sv
// Scoreboard bench for ieee488_handshake with model talker/listener.
// Bus lines are wired-AND of DUT drives and model drives.
module tb_ieee488_handshake;
   localparam int SETTLE  = 4;
   localparam int TIMEOUT = 1024;

   localparam logic [1:0] K_TX  = 2'd0;
   localparam logic [1:0] K_RX  = 2'd1;
   localparam logic [1:0] K_DNP = 2'd2;
   localparam logic [1:0] K_TMO = 2'd3;

   typedef struct packed {
      logic [1:0] kind;
      logic [8:0] val;
   } ev_t;

   logic       clk;
   logic       _reset;
   logic       talk;
   logic       enable;
   logic [7:0] tx_data;
   logic       tx_eoi;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_eoi;
   logic       rx_valid;
   logic       rx_ack;
   logic       busy;
   logic       err_timeout;
   logic       err_dnp;

   logic [7:0] m_dio;
   logic       m_dav;
   logic       m_nrfd;
   logic       m_ndac;
   logic       m_eoi;

   int checks;
   int errors;
   int txr_cnt;
   ev_t exp_q[$];

   ieee488_handshake_if bus();

   assign bus.dio_n  = ~(bus.dio_drv | m_dio);
   assign bus.dav_n  = ~(bus.dav_drv | m_dav);
   assign bus.nrfd_n = ~(bus.nrfd_drv | m_nrfd);
   assign bus.ndac_n = ~(bus.ndac_drv | m_ndac);
   assign bus.eoi_n  = ~(bus.eoi_drv | m_eoi);

   ieee488_handshake #(
      .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .CW(11)
   ) dut (
      .clk(clk), ._reset(_reset), .talk(talk),
      .enable(enable), .tx_data(tx_data),
      .tx_eoi(tx_eoi), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_eoi(rx_eoi), .rx_valid(rx_valid),
      .rx_ack(rx_ack), .bus(bus), .busy(busy),
      .err_timeout(err_timeout), .err_dnp(err_dnp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic sb_pop(input string nm,
                         input logic [1:0] k,
                         input logic [8:0] v);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected event val=%0h", nm, v);
      end else begin
         e = exp_q.pop_front();
         chk({nm, "_kind"}, 32'(k), 32'(e.kind));
         chk({nm, "_val"}, 32'(v), 32'(e.val));
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an event.
   initial begin
      logic       pd, pr, pdn, ptm;
      logic [8:0] last, cur;
      int         stable;
      pd = 0; pr = 0; pdn = 0; ptm = 0;
      last = '0; stable = 0; txr_cnt = 0;
      forever begin
         @(negedge clk);
         if (tx_ready) txr_cnt++;
         cur = {bus.eoi_drv, bus.dio_drv};
         if (cur == last) stable++;
         else stable = 0;
         last = cur;
         if (bus.dav_drv && !pd) begin
            sb_pop("tx_byte", K_TX, cur);
            chk("tx_settle", 32'(stable >= SETTLE), 32'd1);
         end
         if (rx_valid && !pr)
            sb_pop("rx_byte", K_RX, {rx_eoi, rx_data});
         if (err_dnp && !pdn)
            sb_pop("err_dnp", K_DNP, 9'h0);
         if (err_timeout && !ptm)
            sb_pop("err_tmo", K_TMO, 9'h0);
         pd  = bus.dav_drv;
         pr  = rx_valid;
         pdn = err_dnp;
         ptm = err_timeout;
      end
   end

   task automatic push(input logic [1:0] k, input logic [8:0] v);
      ev_t e;
      e.kind = k;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   task automatic start_tx(input logic [7:0] d, input logic e);
      int n;
      tx_data  = d;
      tx_eoi   = e;
      tx_valid = 1'b1;
      talk     = 1'b1;
      enable   = 1'b1;
      n = 0;
      while (!tx_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("tx_take", 32'(tx_ready), 32'd1);
      tx_valid = 1'b0;
   endtask

   task automatic stop_dut();
      enable = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic e);
      int n;
      n = 0;
      while (bus.nrfd_n !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("l_rfd", 32'(bus.nrfd_n), 32'd1);
      m_dio = d;
      m_eoi = e;
      repeat (3) @(negedge clk);
      m_dav = 1'b1;
      n = 0;
      while (bus.ndac_n !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("l_dac", 32'(bus.ndac_n), 32'd1);
      m_dav = 1'b0;
      m_dio = '0;
      m_eoi = 1'b0;
   endtask

   task automatic hold_nrfd(input string nm);
      int bad;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (!bus.nrfd_drv || bus.nrfd_n) bad++;
      end
      chk(nm, 32'(bad), 32'd0);
   endtask

   initial begin
      int n;
      int t0;
      checks = 0; errors = 0;
      _reset = 1'b0; talk = 1'b0; enable = 1'b0;
      tx_data = '0; tx_eoi = 1'b0; tx_valid = 1'b0;
      rx_ack = 1'b0;
      m_dio = '0; m_dav = 1'b0; m_eoi = 1'b0;
      m_nrfd = 1'b1; m_ndac = 1'b1;
      #3;
      chk("rst_out", 32'({busy, tx_ready, rx_valid, rx_eoi,
                          rx_data, err_timeout, err_dnp}), 32'd0);
      chk("rst_drv", 32'({bus.dio_drv, bus.dav_drv, bus.nrfd_drv,
                          bus.ndac_drv, bus.eoi_drv}), 32'd0);
      repeat (2) @(negedge clk);
      _reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Talker: full handshake, listener slow to go ready.
      push(K_TX, 9'h15A);
      t0 = txr_cnt;
      start_tx(8'h5A, 1'b1);
      repeat (8) @(negedge clk);
      chk("dav_hold", 32'(bus.dav_drv), 32'd0);
      chk("dio_drv", 32'({bus.eoi_drv, bus.dio_drv}), 32'h15A);
      m_nrfd = 1'b0;
      n = 0;
      while (!bus.dav_drv && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("dav_rise", 32'(bus.dav_drv), 32'd1);
      m_nrfd = 1'b1;
      m_ndac = 1'b0;
      n = 0;
      while (bus.dav_drv && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("dav_drop", 32'(bus.dav_drv), 32'd0);
      chk("dio_rel", 32'({bus.eoi_drv, bus.dio_drv}), 32'd0);
      m_ndac = 1'b1;
      repeat (6) @(negedge clk);
      chk("t_busy", 32'(busy), 32'd1);
      chk("tx_ready_once", 32'(txr_cnt - t0), 32'd1);
      stop_dut();
      chk("t_idle", 32'(busy), 32'd0);

      // Device not present: both lines released.
      m_nrfd = 1'b0;
      m_ndac = 1'b0;
      push(K_DNP, 9'h0);
      start_tx(8'h33, 1'b0);
      n = 0;
      while (!err_dnp && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("dnp_set", 32'(err_dnp), 32'd1);
      chk("dnp_drv", 32'({bus.dio_drv, bus.dav_drv, bus.nrfd_drv,
                          bus.ndac_drv, bus.eoi_drv}), 32'd0);
      repeat (3) @(negedge clk);
      chk("dnp_sticky", 32'(err_dnp), 32'd1);
      stop_dut();
      chk("dnp_clr", 32'(err_dnp), 32'd0);

      // Timeout: listener never accepts.
      m_nrfd = 1'b0;
      m_ndac = 1'b1;
      push(K_TX, 9'h0C3);
      push(K_TMO, 9'h0);
      start_tx(8'hC3, 1'b0);
      n = 0;
      while (!bus.dav_drv && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_dav", 32'(bus.dav_drv), 32'd1);
      n = 0;
      while (!err_timeout && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", 32'(n), 32'(TIMEOUT));
      chk("tmo_dav_rel", 32'(bus.dav_drv), 32'd0);
      stop_dut();
      chk("tmo_clr", 32'(err_timeout), 32'd0);

      // Listener: two bytes, slow consumer.
      m_nrfd = 1'b0;
      m_ndac = 1'b0;
      push(K_RX, 9'h001);
      push(K_RX, 9'h1FF);
      talk = 1'b0;
      enable = 1'b1;
      repeat (4) @(negedge clk);
      send_byte(8'h01, 1'b0);
      chk("rx1_valid", 32'(rx_valid), 32'd1);
      hold_nrfd("rx1_nrfd");
      rx_ack = 1'b1;
      @(negedge clk);
      rx_ack = 1'b0;
      chk("rx1_pop", 32'(rx_valid), 32'd0);
      send_byte(8'hFF, 1'b1);
      chk("rx2_valid", 32'(rx_valid), 32'd1);
      hold_nrfd("rx2_nrfd");
      stop_dut();
      chk("rx_keep", 32'(rx_valid), 32'd1);

      // Async reset while waiting for acceptance.
      m_nrfd = 1'b0;
      m_ndac = 1'b1;
      push(K_TX, 9'h077);
      start_tx(8'h77, 1'b0);
      n = 0;
      while (!bus.dav_drv && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("rst_dav", 32'(bus.dav_drv), 32'd1);
      #2;
      _reset = 1'b0;
      #1;
      chk("arst_out", 32'({busy, tx_ready, rx_valid,
                           err_timeout, err_dnp}), 32'd0);
      chk("arst_drv", 32'({bus.dio_drv, bus.dav_drv, bus.nrfd_drv,
                           bus.ndac_drv, bus.eoi_drv}), 32'd0);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      _reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst_idle", 32'(busy), 32'd0);

      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
